// File: rtl/ext_tid_rsp_ipa.sv
// Response matcher for external transaction IDs: tracks outstanding TIDs and their
// request metadata, pairs responses with them and presents completions one register deep.
module ext_tid_rsp_ipa #(
    parameter int EXT_TID_WIDTH = 4,
    parameter int META_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_i,
    input  logic [EXT_TID_WIDTH-1:0] issue_tid_i,
    input  logic [META_WIDTH-1:0]    issue_meta_i,
    input  logic                     rsp_valid_i,
    output logic                     rsp_ready_o,
    input  logic [EXT_TID_WIDTH-1:0] rsp_tid_i,
    input  logic [DATA_WIDTH-1:0]    rsp_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [EXT_TID_WIDTH-1:0] out_tid_o,
    output logic [META_WIDTH-1:0]    out_meta_o,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic                     release_tid_o,
    output logic [EXT_TID_WIDTH-1:0] release_tid_id_o,
    output logic                     err_unexp_o,
    output logic                     err_dup_o,
    output logic [EXT_TID_WIDTH:0]   pending_cnt_o
);

    localparam int NB_TID = 2 ** EXT_TID_WIDTH;
    localparam int CNT_W  = EXT_TID_WIDTH + 1;

    logic [NB_TID-1:0]     pending_q;
    logic [NB_TID-1:0]     pending_d;
    logic [META_WIDTH-1:0] meta_mem [NB_TID];

    logic rsp_acc;
    logic rsp_hit;
    logic rsp_miss;
    logic iss_ok;
    logic iss_dup;

    assign rsp_ready_o = !out_valid_o || out_ready_i;
    assign rsp_acc     = rsp_valid_i && rsp_ready_o;

    // Both issue and response look at the pending vector as it was before this edge.
    assign rsp_hit  = rsp_acc && pending_q[rsp_tid_i];
    assign rsp_miss = rsp_acc && !pending_q[rsp_tid_i];
    assign iss_ok   = issue_i && !pending_q[issue_tid_i];
    assign iss_dup  = issue_i && pending_q[issue_tid_i];

    always_comb begin
        pending_d = pending_q;
        if (rsp_hit) begin
            pending_d[rsp_tid_i] = 1'b0;
        end
        if (iss_ok) begin
            pending_d[issue_tid_i] = 1'b1;
        end
    end

    // Metadata is only ever read for pending entries, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (iss_ok) begin
            meta_mem[issue_tid_i] <= issue_meta_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q        <= '0;
            pending_cnt_o    <= '0;
            out_valid_o      <= 1'b0;
            out_tid_o        <= '0;
            out_meta_o       <= '0;
            out_data_o       <= '0;
            release_tid_o    <= 1'b0;
            release_tid_id_o <= '0;
            err_unexp_o      <= 1'b0;
            err_dup_o        <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            pending_cnt_o <= pending_cnt_o + CNT_W'(iss_ok) - CNT_W'(rsp_hit);
            release_tid_o <= rsp_hit;
            err_unexp_o   <= rsp_miss;
            err_dup_o     <= iss_dup;
            if (rsp_hit) begin
                out_valid_o      <= 1'b1;
                out_tid_o        <= rsp_tid_i;
                out_meta_o       <= meta_mem[rsp_tid_i];
                out_data_o       <= rsp_data_i;
                release_tid_id_o <= rsp_tid_i;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
